// File: rtl/vga_pkg.sv
// Shared types, register map, bar-colour table and timing helper for vga_pattern_gen.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID   = 2'd0,
    MODE_BARS    = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_GRAD    = 2'd3
  } mode_e;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_COLOR  = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_POS    = 2'd3;

  // Per-bar {b,g,r} channel on/off flags; index 0 is the leftmost bar.
  // white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [7:0][2:0] BAR_RGB = {
    3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b110, 3'b011, 3'b111
  };

  function automatic int unsigned line_total(int unsigned active, int unsigned fp,
                                             int unsigned sync, int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_core.sv
// Pixel/line counters, sync and active-region generation, and the frame-start pulse.
module vga_timing_core
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned HCntW    = $clog2(line_total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
  parameter int unsigned VCntW    = $clog2(line_total(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             pix_en_i,
  output logic [HCntW-1:0] h_cnt_o,
  output logic [VCntW-1:0] v_cnt_o,
  output logic             active_o,
  output logic             origin_o,
  output logic             hs_o,
  output logic             vs_o,
  output logic             frame_start_o
);

  localparam int unsigned HTotal  = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned VTotal  = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned HsStart = H_ACTIVE + H_FP;
  localparam int unsigned HsEnd   = HsStart + H_SYNC;
  localparam int unsigned VsStart = V_ACTIVE + V_FP;
  localparam int unsigned VsEnd   = VsStart + V_SYNC;

  localparam logic [HCntW-1:0] HLast = HCntW'(HTotal - 1);
  localparam logic [VCntW-1:0] VLast = VCntW'(VTotal - 1);

  logic [HCntW-1:0] h_cnt_q, h_cnt_d;
  logic [VCntW-1:0] v_cnt_q, v_cnt_d;
  logic [31:0]      h_ext, v_ext;
  logic             hs_q, hs_d, vs_q, vs_d;
  logic             fs_q;
  logic             origin;

  assign h_ext  = 32'(h_cnt_q);
  assign v_ext  = 32'(v_cnt_q);
  assign origin = pix_en_i && (h_cnt_q == '0) && (v_cnt_q == '0);

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_en_i) begin
      if (h_cnt_q == HLast) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == VLast) ? '0 : v_cnt_q + VCntW'(1);
      end else begin
        h_cnt_d = h_cnt_q + HCntW'(1);
      end
    end
  end

  always_comb begin
    hs_d = ((h_ext >= HsStart) && (h_ext < HsEnd)) ? SYNC_POL : ~SYNC_POL;
    vs_d = ((v_ext >= VsStart) && (v_ext < VsEnd)) ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      hs_q    <= ~SYNC_POL;
      vs_q    <= ~SYNC_POL;
      fs_q    <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      // Pulse is one clk wide regardless of pix_en rate.
      fs_q    <= origin;
      if (pix_en_i) begin
        hs_q <= hs_d;
        vs_q <= vs_d;
      end
    end
  end

  assign h_cnt_o       = h_cnt_q;
  assign v_cnt_o       = v_cnt_q;
  assign active_o      = (h_ext < H_ACTIVE) && (v_ext < V_ACTIVE);
  assign origin_o      = origin;
  assign hs_o          = hs_q;
  assign vs_o          = vs_q;
  assign frame_start_o = fs_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA timing and test-pattern generator with an Avalon-MM register file and frame-synchronous
// shadow registers. Define VGA_PATTERN_BORDER_EN to draw a one-pixel white border.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int unsigned COLOR_W  = 6,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pix_en,
  input  logic [1:0]         avs_address,
  input  logic               avs_write,
  input  logic [31:0]        avs_writedata,
  input  logic               avs_read,
  output logic [31:0]        avs_readdata,
  output logic [COLOR_W-1:0] vga_r,
  output logic [COLOR_W-1:0] vga_g,
  output logic [COLOR_W-1:0] vga_b,
  output logic               vga_hs,
  output logic               vga_vs,
  output logic               vga_de,
  output logic               frame_start
);

  localparam int unsigned HCntW = $clog2(line_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
  localparam int unsigned VCntW = $clog2(line_total(V_ACTIVE, V_FP, V_SYNC, V_BP));
  localparam int unsigned CfgW  = 3 * COLOR_W;
  localparam logic [COLOR_W-1:0] Full = '1;

  logic [HCntW-1:0] h_cnt;
  logic [VCntW-1:0] v_cnt;
  logic [31:0]      h_ext, v_ext;
  logic             active, origin;

  vga_timing_core #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .SYNC_POL (SYNC_POL),
    .HCntW    (HCntW),
    .VCntW    (VCntW)
  ) u_timing (
    .clk_i         (clk),
    .rst_ni        (reset_n),
    .pix_en_i      (pix_en),
    .h_cnt_o       (h_cnt),
    .v_cnt_o       (v_cnt),
    .active_o      (active),
    .origin_o      (origin),
    .hs_o          (vga_hs),
    .vs_o          (vga_vs),
    .frame_start_o (frame_start)
  );

  assign h_ext = 32'(h_cnt);
  assign v_ext = 32'(v_cnt);

  logic [2:0]         ctrl_q, ctrl_sh_q, ctrl_eff;
  logic [CfgW-1:0]    color_q, color_sh_q, color_eff;
  logic [15:0]        frame_cnt_q;
  logic [31:0]        rdata_q, rd_mux;
  logic               de_q, de_d;
  logic [COLOR_W-1:0] r_q, g_q, b_q;
  logic [COLOR_W-1:0] pix_r, pix_g, pix_b;
  logic [2:0]         bar_idx;
  logic [2:0]         bar;
  mode_e              mode_eff;
  logic               vblank;

  // On the copy cycle the pixel at (0,0) already belongs to the new frame's settings.
  assign ctrl_eff  = origin ? ctrl_q : ctrl_sh_q;
  assign color_eff = origin ? color_q : color_sh_q;
  assign mode_eff  = mode_e'(ctrl_eff[2:1]);
  assign vblank    = (v_ext >= V_ACTIVE);
  assign de_d      = active && ctrl_eff[0];

  // bar_idx = h_cnt*8/H_ACTIVE, as thresholds ceil(k*H_ACTIVE/8).
  always_comb begin
    bar_idx = '0;
    for (int unsigned k = 1; k < 8; k++) begin
      if (h_ext >= (k * H_ACTIVE + 7) / 8) bar_idx = 3'(k);
    end
  end

  assign bar = BAR_RGB[bar_idx];

  always_comb begin
    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    unique case (mode_eff)
      MODE_SOLID: {pix_b, pix_g, pix_r} = color_eff;
      MODE_BARS: begin
        pix_r = bar[0] ? Full : '0;
        pix_g = bar[1] ? Full : '0;
        pix_b = bar[2] ? Full : '0;
      end
      MODE_CHECKER: begin
        if (h_ext[3] ^ v_ext[3]) begin
          pix_r = Full;
          pix_g = Full;
          pix_b = Full;
        end
      end
      MODE_GRAD: begin
        pix_r = h_ext[COLOR_W+1:2];
        pix_g = h_ext[COLOR_W+1:2];
        pix_b = h_ext[COLOR_W+1:2];
      end
      default: ;
    endcase
`ifdef VGA_PATTERN_BORDER_EN
    if ((h_ext == 0) || (h_ext == H_ACTIVE - 1) || (v_ext == 0) || (v_ext == V_ACTIVE - 1)) begin
      pix_r = Full;
      pix_g = Full;
      pix_b = Full;
    end
`endif
  end

  always_comb begin
    rd_mux = '0;
    unique case (avs_address)
      ADDR_CTRL:   rd_mux = 32'(ctrl_q);
      ADDR_COLOR:  rd_mux = 32'(color_q);
      ADDR_STATUS: rd_mux = {15'd0, vblank, frame_cnt_q};
      ADDR_POS:    rd_mux = {16'(v_cnt), 16'(h_cnt)};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q      <= '0;
      color_q     <= '0;
      ctrl_sh_q   <= '0;
      color_sh_q  <= '0;
      frame_cnt_q <= '0;
      rdata_q     <= '0;
      de_q        <= 1'b0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
    end else begin
      if (avs_write && (avs_address == ADDR_CTRL))  ctrl_q  <= avs_writedata[2:0];
      if (avs_write && (avs_address == ADDR_COLOR)) color_q <= avs_writedata[CfgW-1:0];
      // Shadows sample the pre-write front value, so a coinciding write waits a frame.
      if (origin) begin
        ctrl_sh_q   <= ctrl_q;
        color_sh_q  <= color_q;
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      if (avs_read) rdata_q <= rd_mux;
      if (pix_en) begin
        de_q <= de_d;
        r_q  <= de_d ? pix_r : '0;
        g_q  <= de_d ? pix_g : '0;
        b_q  <= de_d ? pix_b : '0;
      end
    end
  end

  logic unused_wdata;
  assign unused_wdata = ^avs_writedata[31:CfgW];

  assign avs_readdata = rdata_q;
  assign vga_de       = de_q;
  assign vga_r        = r_q;
  assign vga_g        = g_q;
  assign vga_b        = b_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed scoreboard bench: small-timing instance against a pixel model, plus a 640-wide
// instance for the colour-bar positions.
module tb_vga_pattern_gen;

  localparam int CW = 6;
  localparam logic [5:0] W = 6'h3F;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, pix_en, avs_write, avs_read;
  logic [1:0]  avs_address;
  logic [31:0] avs_writedata, avs_readdata;
  logic [CW-1:0] vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_de, frame_start;

  logic        pix_en_b, avs_write_b, avs_read_b;
  logic [1:0]  avs_address_b;
  logic [31:0] avs_writedata_b, avs_readdata_b;
  logic [CW-1:0] r_b, g_b, b_b;
  logic        hs_b, vs_b, de_b, fs_b;

  vga_pattern_gen #(
    .COLOR_W(CW), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en), .avs_address(avs_address),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_read(avs_read),
    .avs_readdata(avs_readdata), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de), .frame_start(frame_start)
  );

  vga_pattern_gen #(
    .COLOR_W(CW), .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en_b), .avs_address(avs_address_b),
    .avs_write(avs_write_b), .avs_writedata(avs_writedata_b), .avs_read(avs_read_b),
    .avs_readdata(avs_readdata_b), .vga_r(r_b), .vga_g(g_b), .vga_b(b_b),
    .vga_hs(hs_b), .vga_vs(vs_b), .vga_de(de_b), .frame_start(fs_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_q[$];
  logic [31:0] rd_q[$];

  // Bench model of instance A
  int          mh, mv, frames;
  logic [2:0]  f_ctrl, s_ctrl;
  logic [17:0] f_col, s_col;
  logic [21:0] last_exp;
  localparam logic [21:0] RST_EXP = {1'b0, 1'b1, 1'b1, 1'b0, 18'd0};

  bit          do_rd, do_wr;
  logic [1:0]  addr;
  logic [31:0] w_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [17:0] bar_color(int idx);
    case (idx)
      0: return {W, W, W};        // white
      1: return {6'h0, W, W};     // yellow
      2: return {W, W, 6'h0};     // cyan
      3: return {6'h0, W, 6'h0};  // green
      4: return {W, 6'h0, W};     // magenta
      5: return {6'h0, 6'h0, W};  // red
      6: return {W, 6'h0, 6'h0};  // blue
      default: return 18'd0;      // black
    endcase
  endfunction

  function automatic logic [17:0] model_rgb(int h, int v, logic [2:0] c, logic [17:0] col);
    logic [17:0] px;
    logic [5:0]  gv;
    case (c[2:1])
      2'd0: px = col;
      2'd1: px = bar_color(h * 8 / 8);
      2'd2: px = ((((h / 8) % 2) ^ ((v / 8) % 2)) != 0) ? {W, W, W} : 18'd0;
      default: begin
        gv = 6'((h / 4) % 64);
        px = {gv, gv, gv};
      end
    endcase
`ifdef VGA_PATTERN_BORDER_EN
    if (h == 0 || h == 7 || v == 0 || v == 3) px = {W, W, W};
`endif
    return px;
  endfunction

  function automatic logic [31:0] model_read(logic [1:0] a);
    case (a)
      2'd0: return {29'd0, f_ctrl};
      2'd1: return {14'd0, f_col};
      2'd2: return {15'd0, (mv >= 4), 16'(frames)};
      default: return {16'(mv), 16'(mh)};
    endcase
  endfunction

  task automatic model_reset();
    mh = 0; mv = 0; frames = 0;
    f_ctrl = '0; s_ctrl = '0; f_col = '0; s_col = '0;
    last_exp = RST_EXP;
  endtask

  // One clock on instance A: push expectations, drive, sample #1 after the edge, compare.
  task automatic tick(input bit pe);
    logic [21:0] e;
    logic [2:0]  ec;
    logic [17:0] ecol, rgb;
    bit cp, de, rd;
    rd = do_rd;
    if (do_rd) rd_q.push_back(model_read(addr));
    cp = pe && (mh == 0) && (mv == 0);
    if (pe) begin
      ec   = cp ? f_ctrl : s_ctrl;
      ecol = cp ? f_col : s_col;
      de   = ec[0] && (mh < 8) && (mv < 4);
      rgb  = de ? model_rgb(mh, mv, ec, ecol) : 18'd0;
      e    = {de, !(mh >= 10 && mh < 12), !(mv == 5), cp, rgb};
      if (cp) begin
        s_ctrl = f_ctrl;
        s_col  = f_col;
        frames = (frames + 1) % 65536;
      end
      mh++;
      if (mh == 14) begin
        mh = 0;
        mv = (mv == 6) ? 0 : mv + 1;
      end
    end else begin
      e = last_exp;
      e[18] = 1'b0;
    end
    last_exp = e;
    if (do_wr && addr == 2'd0) f_ctrl = w_data[2:0];
    if (do_wr && addr == 2'd1) f_col = w_data[17:0];
    exp_q.push_back(32'(e));
    pix_en = pe;
    avs_address = addr;
    avs_read = do_rd;
    avs_write = do_wr;
    avs_writedata = w_data;
    @(posedge clk);
    #1;
    avs_read = 1'b0;
    avs_write = 1'b0;
    do_rd = 0;
    do_wr = 0;
    check("pix", 32'({vga_de, vga_hs, vga_vs, frame_start, vga_b, vga_g, vga_r}),
          exp_q.pop_front());
    if (rd) check("readdata", avs_readdata, rd_q.pop_front());
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input bit pe);
    addr = a; w_data = d; do_wr = 1; tick(pe);
  endtask

  task automatic rd(input logic [1:0] a, input bit pe);
    addr = a; do_rd = 1; tick(pe);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1'b1);
  endtask

  initial begin
    int hs_low, de_hi, vs_low;
    bit found;
    reset_n = 1'b0; pix_en = 1'b0; avs_write = 1'b0; avs_read = 1'b0;
    avs_address = '0; avs_writedata = '0;
    pix_en_b = 1'b1; avs_write_b = 1'b0; avs_read_b = 1'b0;
    avs_address_b = '0; avs_writedata_b = '0;
    do_rd = 0; do_wr = 0; addr = '0; w_data = '0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({vga_de, vga_hs, vga_vs, frame_start, vga_b, vga_g, vga_r}),
          32'(RST_EXP));
    check("reset_readdata", avs_readdata, 32'd0);
    reset_n = 1'b1;

    rd(2'd2, 0);
    rd(2'd3, 0);
    rd(2'd0, 0);

    // Disabled: counters and syncs run, de/rgb stay low
    run(30);
    hs_low = 0; de_hi = 0; vs_low = 0;
    for (int i = 0; i < 98; i++) begin
      tick(1'b1);
      hs_low += int'(!vga_hs);
      de_hi  += int'(vga_de);
      vs_low += int'(!vga_vs);
    end
    check("hs_low_per_frame", hs_low, 14);
    check("de_disabled", de_hi, 0);
    check("vs_low_per_frame", vs_low, 14);

    // Mid-frame configure; takes effect only at the next frame start
    while (!(mh == 3 && mv == 1)) tick(1'b1);
    wr(2'd1, 32'h0003F03F, 1);
    wr(2'd0, 32'h1, 1);
    rd(2'd1, 1);
    rd(2'd0, 1);
    while (!(mh == 0 && mv == 0)) tick(1'b1);
    hs_low = 0; de_hi = 0; vs_low = 0;
    for (int i = 0; i < 98; i++) begin
      tick(1'b1);
      hs_low += int'(!vga_hs);
      de_hi  += int'(vga_de);
      vs_low += int'(!vga_vs);
    end
    check("hs_low_enabled", hs_low, 14);
    check("de_high_per_frame", de_hi, 32);
    check("vs_low_enabled", vs_low, 14);

    // Each mode for a frame and a half
    wr(2'd0, 32'h3, 1);   run(150);
    wr(2'd0, 32'h5, 1);   run(150);
    wr(2'd0, 32'h7, 1);   run(150);

    // Write landing exactly on the shadow-copy cycle waits a further frame
    while (!(mh == 0 && mv == 0)) tick(1'b1);
    wr(2'd0, 32'h1, 1);
    run(200);

    // Same-cycle read and write return the old value; RO writes ignored
    rd(2'd2, 1);
    addr = 2'd1; w_data = 32'h00000FC0; do_rd = 1; do_wr = 1; tick(1'b1);
    rd(2'd1, 1);
    wr(2'd2, 32'hFFFF_FFFF, 1);
    wr(2'd3, 32'hFFFF_FFFF, 1);
    rd(2'd2, 1);
    rd(2'd3, 1);
    run(120);

    // pix_en 1-of-4: POS stalls between enables
    for (int i = 0; i < 10; i++) begin
      tick(1'b1);
      rd(2'd3, 0);
      rd(2'd3, 0);
      rd(2'd3, 0);
    end

    // Asynchronous reset mid-frame
    while (mv != 2) tick(1'b1);
    reset_n = 1'b0;
    #1;
    model_reset();
    check("async_reset_outputs",
          32'({vga_de, vga_hs, vga_vs, frame_start, vga_b, vga_g, vga_r}), 32'(RST_EXP));
    tick(1'b0);
    tick(1'b0);
    check("reset_readdata_mid", avs_readdata, 32'd0);
    reset_n = 1'b1;
    rd(2'd2, 0);
    rd(2'd3, 0);
    rd(2'd0, 0);
    wr(2'd0, 32'h1, 0);
    run(110);
    rd(2'd2, 1);

    // Colour bars at 640 wide, checked on line 1
    avs_address_b = 2'd0; avs_writedata_b = 32'h3; avs_write_b = 1'b1;
    @(posedge clk);
    #1;
    avs_write_b = 1'b0;
    found = 0;
    for (int i = 0; i < 12000 && !found; i++) begin
      @(posedge clk);
      #1;
      if (fs_b) found = 1;
    end
    check("b_frame_start_seen", 32'(found), 32'd1);
    if (found) begin
      exp_q.push_back({13'd0, 1'b1, W, W, W});
      check("b_px0_0_white", 32'({de_b, b_b, g_b, r_b}), exp_q.pop_front());
      repeat (800) @(posedge clk);
      #1;
      exp_q.push_back({13'd0, 1'b1, W, W, W});
      check("b_px0_1_white", 32'({de_b, b_b, g_b, r_b}), exp_q.pop_front());
      repeat (80) @(posedge clk);
      #1;
      exp_q.push_back({13'd0, 1'b1, 6'h0, W, W});
      check("b_px80_1_yellow", 32'({de_b, b_b, g_b, r_b}), exp_q.pop_front());
      repeat (559) @(posedge clk);
      #1;
`ifdef VGA_PATTERN_BORDER_EN
      exp_q.push_back({13'd0, 1'b1, W, W, W});
`else
      exp_q.push_back({13'd0, 1'b1, 18'd0});
`endif
      check("b_px639_1", 32'({de_b, b_b, g_b, r_b}), exp_q.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
